// File: rtl/digitizer_fifo_pkg.sv
// -----------------------------------------------------------------------------
// digitizer_fifo_pkg
// Shared definitions for the digitizer sync FIFO:
//   - clog2()        : ceiling log2 used to size pointers and the word count
//   - PIPE_NONE/OUT  : output pipelining selections for the PIPE parameter
//   - fifo_status_t  : registered status flags kept as one struct
//   - STATUS_RESET   : flag values after reset or flush
// -----------------------------------------------------------------------------
package digitizer_fifo_pkg;

    localparam int PIPE_NONE = 0;  // RDATA comes straight from the RAM read register
    localparam int PIPE_OUT  = 1;  // one extra output register after the RAM

    typedef struct packed {
        logic full;
        logic empty;
        logic afull;
        logic aempty;
        logic overflow;
        logic underflow;
    } fifo_status_t;

    localparam fifo_status_t STATUS_RESET = '{
        full: 1'b0, empty: 1'b1, afull: 1'b0, aempty: 1'b1,
        overflow: 1'b0, underflow: 1'b0
    };

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/digitizer_fifo_ram.sv
// -----------------------------------------------------------------------------
// digitizer_fifo_ram
// Inferred simple-dual-port RAM (one write port, one registered read port)
// intended to map onto LSRAM.
// Parameters: DW data width, AW address width (2**AW words).
// Ports:
//   clk, rst_n        clock, async active-low reset (read register only)
//   we, waddr, wdata  write port
//   re, raddr         read port; rdata updates on the clock after re
//   rdata             registered read data, holds while re is low
// -----------------------------------------------------------------------------
module digitizer_fifo_ram #(
    parameter int DW = 32,
    parameter int AW = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    // NOTE: the storage array gets no reset -- a reset would stop it mapping
    // onto block RAM and the FIFO never reads a word it has not written.
    // NOTE: sequential state always uses non-blocking assignment so every
    // register samples its inputs from before the clock edge.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // The output register carries the reset so RDATA starts at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/digitizer_sync_fifo.sv
// -----------------------------------------------------------------------------
// digitizer_sync_fifo
// Single-clock FIFO between the ADC sample packer and readout/DMA.
// Owns write/read pointers, the word count, registered status flags, an
// optional output register and a synchronous flush (CLR, priority over WE/RE).
// Optional feature macro: FIFO_PARITY_EN -- stores an even-parity bit with each
// word and flags PERR alongside RVALID when the read-back parity disagrees.
// Ports:
//   CLOCK, RESET_N      clock, async active-low reset
//   CLR                 synchronous flush
//   WDATA, WE           write data / write request (ignored while FULL)
//   RE                  read request (ignored while EMPTY)
//   RDATA, RVALID       read data and its one-cycle valid pulse
//   FULL, EMPTY, AFULL, AEMPTY   registered status
//   WRCNT               current word count
//   OVERFLOW, UNDERFLOW sticky error flags, cleared by reset or CLR
//   PERR                parity error on the current RVALID word
// -----------------------------------------------------------------------------
module digitizer_sync_fifo
    import digitizer_fifo_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 128,
    parameter int PIPE      = PIPE_OUT,
    parameter int AFULL_TH  = DEPTH - 4,
    parameter int AEMPTY_TH = 4
) (
    input  logic                  CLOCK,
    input  logic                  RESET_N,
    input  logic                  CLR,
    input  logic [WIDTH-1:0]      WDATA,
    input  logic                  WE,
    input  logic                  RE,
    output logic [WIDTH-1:0]      RDATA,
    output logic                  RVALID,
    output logic                  FULL,
    output logic                  EMPTY,
    output logic                  AFULL,
    output logic                  AEMPTY,
    output logic [clog2(DEPTH):0] WRCNT,
    output logic                  OVERFLOW,
    output logic                  UNDERFLOW,
    output logic                  PERR
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = AW + 1;
`ifdef FIFO_PARITY_EN
    localparam int MW = WIDTH + 1;
`else
    localparam int MW = WIDTH;
`endif
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_TH);

    logic [AW-1:0] wptr, rptr;
    logic [CW-1:0] count, count_nxt;
    fifo_status_t  status, status_nxt;
    logic          wr_acc, rd_acc;
    logic          ram_valid;
    logic [MW-1:0] ram_wdata, ram_rdata;
    logic          perr_raw;

    // Status is registered, so acceptance uses the current-cycle flags.
    assign wr_acc = WE & ~status.full  & ~CLR;
    assign rd_acc = RE & ~status.empty & ~CLR;

    // NOTE: every output of a combinational block is given a default first so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        count_nxt = count;
        if (CLR) begin
            count_nxt = '0;
        end else if (wr_acc && !rd_acc) begin
            count_nxt = count + CW'(1);
        end else if (rd_acc && !wr_acc) begin
            count_nxt = count - CW'(1);
        end
    end

    // Flags come from the next count so they line up with WRCNT.
    always_comb begin
        status_nxt           = STATUS_RESET;
        status_nxt.full      = (count_nxt == DEPTH_C);
        status_nxt.empty     = (count_nxt == '0);
        status_nxt.afull     = (count_nxt >= AFULL_C);
        status_nxt.aempty    = (count_nxt <= AEMPTY_C);
        status_nxt.overflow  = ~CLR & (status.overflow  | (WE & status.full));
        status_nxt.underflow = ~CLR & (status.underflow | (RE & status.empty));
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            status    <= STATUS_RESET;
            ram_valid <= 1'b0;
        end else begin
            count     <= count_nxt;
            status    <= status_nxt;
            ram_valid <= rd_acc;
            if (CLR) begin
                wptr <= '0;
                rptr <= '0;
            end else begin
                if (wr_acc) wptr <= wptr + AW'(1);
                if (rd_acc) rptr <= rptr + AW'(1);
            end
        end
    end

`ifdef FIFO_PARITY_EN
    assign ram_wdata = {^WDATA, WDATA};
    // Recompute parity on the RAM output and compare with the stored bit.
    assign perr_raw  = (^ram_rdata[WIDTH-1:0]) ^ ram_rdata[WIDTH];
`else
    assign ram_wdata = WDATA;
    assign perr_raw  = 1'b0;
`endif

    digitizer_fifo_ram #(
        .DW (MW),
        .AW (AW)
    ) u_ram (
        .clk   (CLOCK),
        .rst_n (RESET_N),
        .we    (wr_acc),
        .waddr (wptr),
        .wdata (ram_wdata),
        .re    (rd_acc),
        .raddr (rptr),
        .rdata (ram_rdata)
    );

    generate
        if (PIPE == PIPE_OUT) begin : g_pipe_out
            logic [WIDTH-1:0] rdata_q;
            logic             rvalid_q;
            logic             perr_q;

            // A flush kills the word in flight and leaves RDATA unchanged.
            always_ff @(posedge CLOCK or negedge RESET_N) begin
                if (!RESET_N) begin
                    rdata_q  <= '0;
                    rvalid_q <= 1'b0;
                    perr_q   <= 1'b0;
                end else begin
                    rvalid_q <= ram_valid & ~CLR;
                    perr_q   <= ram_valid & ~CLR & perr_raw;
                    if (ram_valid && !CLR) begin
                        rdata_q <= ram_rdata[WIDTH-1:0];
                    end
                end
            end

            assign RDATA  = rdata_q;
            assign RVALID = rvalid_q;
            assign PERR   = perr_q;
        end else begin : g_pipe_none
            assign RDATA  = ram_rdata[WIDTH-1:0];
            assign RVALID = ram_valid;
            assign PERR   = ram_valid & perr_raw;
        end
    endgenerate

    assign FULL      = status.full;
    assign EMPTY     = status.empty;
    assign AFULL     = status.afull;
    assign AEMPTY    = status.aempty;
    assign OVERFLOW  = status.overflow;
    assign UNDERFLOW = status.underflow;
    assign WRCNT     = count;

endmodule

// File: tb/tb_digitizer_sync_fifo.sv
// -----------------------------------------------------------------------------
// tb_digitizer_sync_fifo
// Drives two FIFOs (PIPE=0 and PIPE=1, WIDTH=32, DEPTH=128) from one stimulus
// stream. A queue-based model of FIFO behaviour predicts every output of both
// instances each cycle; directed literal expectations pin the model.
// Define FIFO_PARITY_EN to also exercise the parity path.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_digitizer_sync_fifo;

    localparam int W = 32;
    localparam int D = 128;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         clr   = 1'b0;
    logic         we    = 1'b0;
    logic         re    = 1'b0;
    logic [W-1:0] wdata = '0;

    logic [W-1:0] rdata0, rdata1;
    logic         rvalid0, rvalid1, full0, full1, empty0, empty1;
    logic         afull0, afull1, aempty0, aempty1;
    logic [7:0]   wrcnt0, wrcnt1;
    logic         ovf0, ovf1, unf0, unf1, perr0, perr1;

    always #5 clk = ~clk;

    digitizer_sync_fifo #(.WIDTH(W), .DEPTH(D), .PIPE(0), .AFULL_TH(124), .AEMPTY_TH(4)) dut0 (
        .CLOCK(clk), .RESET_N(rst_n), .CLR(clr), .WDATA(wdata), .WE(we), .RE(re),
        .RDATA(rdata0), .RVALID(rvalid0), .FULL(full0), .EMPTY(empty0),
        .AFULL(afull0), .AEMPTY(aempty0), .WRCNT(wrcnt0),
        .OVERFLOW(ovf0), .UNDERFLOW(unf0), .PERR(perr0)
    );

    digitizer_sync_fifo #(.WIDTH(W), .DEPTH(D), .PIPE(1), .AFULL_TH(124), .AEMPTY_TH(4)) dut1 (
        .CLOCK(clk), .RESET_N(rst_n), .CLR(clr), .WDATA(wdata), .WE(we), .RE(re),
        .RDATA(rdata1), .RVALID(rvalid1), .FULL(full1), .EMPTY(empty1),
        .AFULL(afull1), .AEMPTY(aempty1), .WRCNT(wrcnt1),
        .OVERFLOW(ovf1), .UNDERFLOW(unf1), .PERR(perr1)
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- model: stored words + per-latency delivery lists -------
    typedef struct {
        logic [W-1:0] d;
        bit           bad;
    } ent_t;
    typedef struct {
        int           due;
        logic [W-1:0] d;
        bit           bad;
    } pend_t;

    ent_t         mq[$];
    pend_t        p0[$];
    pend_t        p1[$];
    int           ec;
    bit           m_ovf, m_unf;
    bit           e_rv0, e_rv1, e_pe0, e_pe1;
    logic [W-1:0] e_rd0, e_rd1;

    task automatic model_reset();
        mq.delete(); p0.delete(); p1.delete();
        ec = 0; m_ovf = 0; m_unf = 0;
        e_rv0 = 0; e_rv1 = 0; e_pe0 = 0; e_pe1 = 0;
        e_rd0 = '0; e_rd1 = '0;
    endtask

    // Called once per rising edge with the inputs that edge sampled.
    task automatic model_update();
        ent_t  e;
        pend_t pt;
        bit    is_full, is_empty;
        ec++;
        if (clr) begin
            mq.delete(); p0.delete(); p1.delete();
            m_ovf = 0; m_unf = 0;
        end else begin
            is_full  = (mq.size() == D);
            is_empty = (mq.size() == 0);
            if (we && is_full)  m_ovf = 1;
            if (re && is_empty) m_unf = 1;
            if (re && !is_empty) begin
                e = mq.pop_front();
                pt.d = e.d; pt.bad = e.bad;
                pt.due = ec;     p0.push_back(pt);  // visible 1 cycle after accept
                pt.due = ec + 1; p1.push_back(pt);  // visible 2 cycles after accept
            end
            if (we && !is_full) begin
                e.d = wdata; e.bad = 0;
                mq.push_back(e);
            end
        end
        e_rv0 = 0; e_pe0 = 0;
        if (p0.size() > 0 && p0[0].due == ec) begin
            e_rv0 = 1; e_rd0 = p0[0].d; e_pe0 = p0[0].bad;
            void'(p0.pop_front());
        end
        e_rv1 = 0; e_pe1 = 0;
        if (p1.size() > 0 && p1[0].due == ec) begin
            e_rv1 = 1; e_rd1 = p1[0].d; e_pe1 = p1[0].bad;
            void'(p1.pop_front());
        end
    endtask

    task automatic cmp(input string tag, input logic [W-1:0] rd, input logic rv,
                       input logic fu, input logic em, input logic af, input logic ae,
                       input logic [7:0] cnt, input logic ov, input logic un, input logic pe,
                       input bit x_rv, input logic [W-1:0] x_rd, input bit x_pe);
        int sz;
        sz = mq.size();
        check({tag, ".wrcnt"},     cnt, 64'(sz));
        check({tag, ".full"},      fu,  64'(sz == D));
        check({tag, ".empty"},     em,  64'(sz == 0));
        check({tag, ".afull"},     af,  64'(sz >= 124));
        check({tag, ".aempty"},    ae,  64'(sz <= 4));
        check({tag, ".overflow"},  ov,  64'(m_ovf));
        check({tag, ".underflow"}, un,  64'(m_unf));
        check({tag, ".rvalid"},    rv,  64'(x_rv));
        check({tag, ".rdata"},     rd,  64'(x_rd));
        check({tag, ".perr"},      pe,  64'(x_pe));
    endtask

    // Single compare process, sampling on the falling edge.
    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            cmp("p0", rdata0, rvalid0, full0, empty0, afull0, aempty0, wrcnt0, ovf0, unf0, perr0,
                e_rv0, e_rd0, e_pe0);
            cmp("p1", rdata1, rvalid1, full1, empty1, afull1, aempty1, wrcnt1, ovf1, unf1, perr1,
                e_rv1, e_rd1, e_pe1);
        end
    end

    task automatic step(input bit w, input bit r, input bit c, input logic [W-1:0] d);
        we = w; re = r; clr = c; wdata = d;
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, '0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check("rst.rdata",     rdata1,  0);
        check("rst.rvalid",    rvalid1, 0);
        check("rst.wrcnt",     wrcnt1,  0);
        check("rst.empty",     empty1,  1);
        check("rst.aempty",    aempty1, 1);
        check("rst.full",      full1,   0);
        check("rst.afull",     afull1,  0);
        check("rst.overflow",  ovf1,    0);
        check("rst.underflow", unf1,    0);
        check("rst.perr",      perr1,   0);
        check("rst.p0.rdata",  rdata0,  0);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Fill with 0x1..0x80.
        for (int i = 1; i <= D; i++) begin
            step(1, 0, 0, W'(i));
            if (i == 123) check("fill.afull@123", afull1, 0);
            if (i == 124) check("fill.afull@124", afull1, 1);
            if (i == 127) check("fill.full@127",  full1,  0);
        end
        check("fill.wrcnt", wrcnt1, 128);
        check("fill.full",  full1,  1);

        // Drain in order.
        for (int i = 0; i < D; i++) begin
            step(0, 1, 0, '0);
            if (i == 0) check("drain.first", rdata0, 32'h1);
        end
        idle(2);
        check("drain.empty",  empty1, 1);
        check("drain.last0",  rdata0, 32'h80);
        check("drain.last1",  rdata1, 32'h80);

        // WE+RE on full: read accepted, write rejected.
        for (int i = 0; i < D; i++) step(1, 0, 0, 32'h100 + W'(i));
        step(1, 1, 0, 32'hDEAD);
        check("ovf.wrcnt",    wrcnt1, 127);
        check("ovf.flag",     ovf1,   1);
        check("ovf.rdata",    rdata0, 32'h100);
        idle(3);
        check("ovf.sticky",   ovf1,   1);
        for (int i = 0; i < 127; i++) step(0, 1, 0, '0);
        idle(2);
        check("ovf.drained",  empty1, 1);

        // RE+WE on empty: write accepted, read rejected.
        step(1, 1, 0, 32'h55);
        check("unf.wrcnt",    wrcnt1,  1);
        check("unf.flag",     unf1,    1);
        check("unf.rvalid0",  rvalid0, 0);
        idle(1);
        check("unf.rvalid1",  rvalid1, 0);

        // Read latency, PIPE=0 vs PIPE=1.
        step(0, 1, 0, '0);
        check("lat.rv0@1", rvalid0, 1);
        check("lat.rv1@1", rvalid1, 0);
        check("lat.rd0",   rdata0,  32'h55);
        idle(1);
        check("lat.rv0@2", rvalid0, 0);
        check("lat.rv1@2", rvalid1, 1);
        check("lat.rd1",   rdata1,  32'h55);

        // Full-rate streaming.
        for (int i = 0; i < 10; i++) step(1, 0, 0, 32'h200 + W'(i));
        for (int i = 0; i < 20; i++) begin
            step(1, 1, 0, 32'h300 + W'(i));
            check("rate.wrcnt", wrcnt1,  10);
            check("rate.rv0",   rvalid0, 1);
            if (i > 0) check("rate.rv1", rvalid1, 1);
        end

        // Flush at 50 words with WE/RE and a read in flight.
        for (int i = 0; i < 40; i++) step(1, 0, 0, 32'h400 + W'(i));
        check("clr.pre.wrcnt", wrcnt1, 50);
        step(1, 1, 0, 32'h4FF);
        step(1, 1, 1, 32'h777);
        check("clr.wrcnt",  wrcnt1,  0);
        check("clr.empty",  empty1,  1);
        check("clr.aempty", aempty1, 1);
        check("clr.ovf",    ovf1,    0);
        check("clr.unf",    unf1,    0);
        check("clr.rv1",    rvalid1, 0);
        check("clr.rv0",    rvalid0, 0);
        step(1, 0, 0, 32'hA5);
        step(0, 1, 0, '0);
        check("clr.a5.p0", rdata0, 32'hA5);
        idle(1);
        check("clr.a5.p1", rdata1, 32'hA5);
        check("clr.a5.rv", rvalid1, 1);

        // Asynchronous reset in mid-operation.
        step(1, 0, 0, 32'h11);
        step(1, 0, 0, 32'h22);
        step(0, 1, 0, '0);
        #2 rst_n = 1'b0;
        #1;
        check("arst.rvalid", rvalid1, 0);
        check("arst.rdata",  rdata1,  0);
        check("arst.wrcnt",  wrcnt1,  0);
        check("arst.empty",  empty1,  1);
        check("arst.rdata0", rdata0,  0);
        model_reset();
        we = 0; re = 0; clr = 0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);

`ifdef FIFO_PARITY_EN
        // Corrupt the stored parity bit of the second word only.
        step(1, 0, 0, 32'hF0);
        step(1, 0, 0, 32'hF1);
        step(1, 0, 0, 32'hF2);
        dut0.u_ram.mem[1][W] = ~dut0.u_ram.mem[1][W];
        dut1.u_ram.mem[1][W] = ~dut1.u_ram.mem[1][W];
        mq[1].bad = 1;
        step(0, 1, 0, '0);
        check("par.w0.p0", perr0, 0);
        step(0, 1, 0, '0);
        check("par.w1.p0", perr0, 1);
        check("par.w0.p1", perr1, 0);
        step(0, 1, 0, '0);
        check("par.w1.p1", perr1, 1);
        idle(2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/digitizer_sync_fifo.md
# digitizer_sync_fifo

Parametrised single-clock FIFO that sits between the ADC sample packer and the readout/DMA logic. It replaces the fixed 32x128 controller-plus-LSRAM wrapper with a block that owns its pointers, a word count, status flags, selectable output pipelining and a synchronous flush. Storage is an inferred simple-dual-port RAM with a registered read port, mapped to LSRAM by synthesis.

## Interface
Parameters:
- WIDTH, 32, data word width (1..64).
- DEPTH, 128, number of words; power of two, 4..4096.
- PIPE, 1, 0 = RAM output register only; 1 = extra output register.
- AFULL_TH, DEPTH-4, AFULL asserted when count >= AFULL_TH.
- AEMPTY_TH, 4, AEMPTY asserted when count <= AEMPTY_TH.

Ports:
- CLOCK  in  1  single clock; all logic on rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- CLR  in  1  synchronous flush.
- WDATA  in  WIDTH  write data.
- WE  in  1  write request.
- RE  in  1  read request.
- RDATA  out  WIDTH  read data, qualified by RVALID.
- RVALID  out  1  RDATA holds a newly read word this cycle.
- FULL, EMPTY, AFULL, AEMPTY  out  1 each  registered status.
- WRCNT  out  clog2(DEPTH)+1  current word count.
- OVERFLOW, UNDERFLOW  out  1 each  sticky error flags.
- PERR  out  1  parity error on the current RVALID word (only with the macro).

## Operation
- Write accepted = WE & !FULL. A write accepted in cycle n stores WDATA at wptr and increments wptr modulo DEPTH.
- Read accepted = RE & !EMPTY. A read accepted in cycle n reads rptr and increments rptr modulo DEPTH.
- WE while FULL is rejected, including when RE is asserted in the same cycle. It sets OVERFLOW.
- RE while EMPTY is rejected, including when WE is asserted in the same cycle. It sets UNDERFLOW.
- Count update: +1 on accepted write only, -1 on accepted read only, unchanged when both or neither are accepted.
- The count never exceeds DEPTH and never goes below 0.
- Flags are registered from the next-count value, so they are valid in the same cycle as WRCNT:
  - FULL = count==DEPTH
  - EMPTY = count==0
  - AFULL = count>=AFULL_TH
  - AEMPTY = count<=AEMPTY_TH
- Read and write addresses cannot collide on an accepted operation, so no read-during-write handling is required.
- CLR has priority over WE and RE. On CLR:
  - pointers and count go to 0; EMPTY=1, AEMPTY=1, FULL=0, AFULL=0
  - OVERFLOW and UNDERFLOW clear
  - RVALID and in-flight pipeline valids clear; RDATA holds its value
  - RAM contents are untouched
- OVERFLOW and UNDERFLOW clear only on reset or CLR.

## Timing
- Reset values:
  - RDATA=0, RVALID=0, WRCNT=0, EMPTY=1, AEMPTY=1
  - FULL=0, AFULL=0, OVERFLOW=0, UNDERFLOW=0, PERR=0
  - pointers = 0
- Read latency from the cycle a read is accepted to RVALID=1:
  - PIPE=0: 1 cycle
  - PIPE=1: 2 cycles
- RVALID is a single-cycle pulse per accepted read. Back-to-back reads give back-to-back RVALID.
- Write-to-read: a word written in cycle n produces EMPTY=0 at n+1 and can be read from n+1.
- Full throughput: one write and one read per cycle, sustained.
- If reset asserts mid-operation, everything returns to reset values immediately (asynchronous). Pipelined data is discarded.

## Configuration
- FIFO_PARITY_EN defined:
  - each RAM word is WIDTH+1 bits; the extra bit is the even parity of WDATA, computed on write
  - on read, parity is recomputed at the RAM output and registered alongside the data
  - PERR=1 with RVALID when stored and recomputed parity differ; PERR=0 otherwise
- FIFO_PARITY_EN undefined: RAM is WIDTH bits and PERR is tied to 0.

## Structure
- Shared package digitizer_fifo_pkg:
  - clog2 function
  - PIPE_NONE/PIPE_OUT constants
  - a status-flag struct typedef (full, empty, afull, aempty, overflow, underflow)
- Sub-module digitizer_fifo_ram: inferred simple-dual-port RAM, parameters DW and AW, one write port, one registered read port with read enable.
- Pointers, count, flags and the output pipeline live in the top module.

## Test plan
- Reset, then write 0x1..0x80 with WIDTH=32, DEPTH=128 → FULL=1 and WRCNT=128 after the 128th write; AFULL=1 from count 124. Then read all 128 words → data returns in order 0x1..0x80, EMPTY=1 at the end.
- WE on a full FIFO together with RE → read accepted, write rejected, WRCNT=127, OVERFLOW=1 and stays set.
- RE on an empty FIFO together with WE → write accepted, WRCNT=1, UNDERFLOW=1, no RVALID.
- PIPE=0 vs PIPE=1 → RVALID rises 1 cycle vs 2 cycles after the accepted RE. Continuous RE/WE at full rate keeps WRCNT constant and yields one RVALID per cycle.
- Fill to 50, assert CLR together with WE and RE → WRCNT=0, EMPTY=1, pending RVALID suppressed, sticky flags cleared. Write 0xA5 → it reads back as 0xA5.
- With FIFO_PARITY_EN defined, force-flip one stored bit → PERR=1 with that word's RVALID; all other words read with PERR=0.
